clock_reset_sequencer: RTL and testbench

- Controls the VGA pixel-clock MMCM: pulses its reset, waits for a debounced lock, then releases the pixel-domain reset.
- Monitors lock continuously; on lock loss or lock timeout it re-sequences, and after a bounded number of failed attempts it raises a sticky fault.
- Clocked on the free-running 100 MHz board clock. Sits between the board reset pin, the clock generator's RST/locked, and the 25 MHz VGA timing logic.

---
 rtl/clock_reset_pkg.sv | 14 +
 rtl/sync_ff.sv | 15 +
 rtl/clock_reset_sequencer.sv | 93 +++++++++
 tb/tb_clock_reset_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_reset_pkg.sv
// clock_reset_pkg: shared state encoding and counter-width helper for the clock/reset sequencer.
package clock_reset_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop single-bit synchronizer with asynchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: pulses MMCM reset, waits for debounced lock, releases pixel reset; retries then faults.
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int SYNC_STAGES         = 2,
  localparam int RC_W               = cnt_w(MAX_RETRIES + 1)
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               locked_in,
  input  logic               force_relock,
  input  logic               clear_fault,
  output logic               mmcm_reset,
  output logic               pixel_reset_n,
  output logic               ready,
  output logic               fault,
  output logic [RC_W-1:0]    retry_count,
  output logic [STATE_W-1:0] state
);
  localparam int HOLD_W = cnt_w(RESET_HOLD_CYCLES);
  localparam int TO_W   = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int ST_W   = cnt_w(STABLE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0]   STABLE_LAST = ST_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]   RETRY_LAST  = RC_W'(MAX_RETRIES - 1);
  seq_state_t        cur, nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ST_W-1:0]   stable_cnt;
  logic [RC_W-1:0]   retry_n;
  logic              lock_s, attempt, timeout, give_up, relock;
  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (clk_in),
    .rst_n(reset_n),
    .d    (locked_in),
    .q    (lock_s)
  );
  assign attempt = cur == WAIT_LOCK || cur == STABLE;
  assign timeout = attempt && to_cnt == TO_LAST;
  assign give_up = timeout && retry_count == RETRY_LAST;
  // A relock request beats everything except the final give-up into FAULT.
  assign relock  = force_relock && cur != FAULT && !give_up;
  assign state   = cur;
  always_comb begin
    nxt     = cur;
    retry_n = retry_count;
    case (cur)
      HOLD:      nxt = hold_cnt == HOLD_LAST ? WAIT_LOCK : HOLD;
      WAIT_LOCK: nxt = lock_s ? STABLE : WAIT_LOCK;
      STABLE:    nxt = !lock_s ? WAIT_LOCK : (stable_cnt == STABLE_LAST ? RUN : STABLE);
      RUN:       nxt = lock_s ? RUN : HOLD;
      FAULT:     nxt = clear_fault ? HOLD : FAULT;
      default:   nxt = HOLD;
    endcase
    if ((cur == STABLE && nxt == RUN) || (cur == FAULT && clear_fault)) retry_n = '0;
    if (timeout) begin
      nxt     = give_up ? FAULT : HOLD;
      retry_n = retry_count + 1'b1;
    end
    if (relock) begin
      nxt     = HOLD;
      retry_n = retry_count;
    end
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      cur           <= HOLD;
      hold_cnt      <= '0;
      to_cnt        <= '0;
      stable_cnt    <= '0;
      retry_count   <= '0;
      mmcm_reset    <= 1'b1;
      pixel_reset_n <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      cur           <= nxt;
      hold_cnt      <= (cur == HOLD && nxt == HOLD && !relock) ? hold_cnt + 1'b1 : '0;
      to_cnt        <= (attempt && (nxt == WAIT_LOCK || nxt == STABLE)) ? to_cnt + 1'b1 : '0;
      stable_cnt    <= (cur == STABLE && nxt == STABLE) ? stable_cnt + 1'b1 : '0;
      retry_count   <= retry_n;
      mmcm_reset    <= nxt == HOLD || nxt == FAULT;
      pixel_reset_n <= nxt == RUN;
      ready         <= nxt == RUN;
      fault         <= nxt == FAULT;
    end
endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb_clock_reset_sequencer: randomized scenario bench against a streak/age-based reference model.
module tb_clock_reset_sequencer;
  localparam int HOLD_C = 4, TO_C = 50, ST_C = 8, MAXR_C = 3, SYNC_C = 2;
  localparam logic [8:0] RST_VEC = 9'b000_00_1000;
  logic clk_in = 1'b0, reset_n = 1'b0, locked_in = 1'b0, force_relock = 1'b0, clear_fault = 1'b0;
  logic mmcm_reset, pixel_reset_n, ready, fault;
  logic [1:0] retry_count;
  logic [2:0] state;
  logic [8:0] obs;
  int n_tests = 0, n_fail = 0;
  int m_state, m_retry, m_hold_age, m_age, m_streak;
  logic [SYNC_C-1:0] m_pipe;

  clock_reset_sequencer #(
    .RESET_HOLD_CYCLES(HOLD_C), .LOCK_TIMEOUT_CYCLES(TO_C), .STABLE_CYCLES(ST_C),
    .MAX_RETRIES(MAXR_C), .SYNC_STAGES(SYNC_C)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .locked_in(locked_in), .force_relock(force_relock),
    .clear_fault(clear_fault), .mmcm_reset(mmcm_reset), .pixel_reset_n(pixel_reset_n),
    .ready(ready), .fault(fault), .retry_count(retry_count), .state(state)
  );

  always #5 clk_in = ~clk_in;
  assign obs = {state, retry_count, mmcm_reset, pixel_reset_n, ready, fault};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_state = 0; m_retry = 0; m_hold_age = 0; m_age = 0; m_streak = 0; m_pipe = '0;
  endtask

  // Attempt phase = WAIT_LOCK/STABLE: RUN once the lock streak reaches STABLE+1, timeout by attempt age.
  task automatic model_step(input logic lk, input logic fr, input logic cf);
    logic ls;
    int nxt, nr;
    ls = m_pipe[SYNC_C-1];
    m_pipe = {m_pipe[SYNC_C-2:0], lk};
    nxt = m_state;
    nr = m_retry;
    case (m_state)
      0: begin
        m_hold_age++;
        if (m_hold_age == HOLD_C) begin nxt = 1; m_age = 0; m_streak = 0; end
      end
      1, 2: begin
        m_age++;
        m_streak = ls ? m_streak + 1 : 0;
        if (m_age == TO_C) begin nr = m_retry + 1; nxt = (nr == MAXR_C) ? 4 : 0; end
        else if (m_streak == ST_C + 1) begin nxt = 3; nr = 0; end
        else nxt = (m_streak > 0) ? 2 : 1;
      end
      3: if (!ls) nxt = 0;
      default: if (cf) begin nxt = 0; nr = 0; end
    endcase
    if (fr && m_state != 4 && nxt != 4) begin nxt = 0; nr = m_retry; end
    if (nxt == 0 && (m_state != 0 || fr)) m_hold_age = 0;
    m_state = nxt;
    m_retry = nr;
  endtask

  function automatic logic [8:0] exp_vec();
    return {3'(m_state), 2'(m_retry), m_state == 0 || m_state == 4, m_state == 3, m_state == 3, m_state == 4};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_step(locked_in, force_relock, clear_fault);
    #1;
  endtask

  task automatic restart();
    @(negedge clk_in);
    reset_n = 1'b0; locked_in = 1'b0; force_relock = 1'b0; clear_fault = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    n_tests++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_values: got %b required %b", obs, RST_VEC); end
    locked_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_hold_with_lock: got %b required %b", obs, RST_VEC); end
  endtask

  task automatic test_normal_lock();
    int rise, lat;
    restart();
    rise = $urandom_range(8, 12);
    for (int i = 0; i < rise; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL normal_pre_lock t%0d: got %b required %b", i, obs, exp_vec()); end
    end
    locked_in = 1'b1;
    lat = 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL normal_lock t%0d: got %b required %b", lat, obs, exp_vec()); end
    end
    n_tests++;
    if (lat < 9 || lat > 11) begin n_fail++; $display("FAIL normal_lock_latency: got %0d cycles required 9..11", lat); end
    n_tests++;
    if (retry_count !== 2'd0 || pixel_reset_n !== 1'b1) begin
      n_fail++; $display("FAIL normal_run_outputs: got retry=%0d prst=%b required retry=0 prst=1", retry_count, pixel_reset_n);
    end
  endtask

  task automatic test_glitchy_lock();
    int lat;
    logic saw_hold, saw_back;
    logic [2:0] prev;
    restart();
    saw_hold = 1'b0; saw_back = 1'b0;
    for (int i = 0; i < 6 + 5 + 1; i++) begin
      locked_in = (i >= 6 && i < 11);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_pre t%0d: got %b required %b", i, obs, exp_vec()); end
    end
    locked_in = 1'b1;
    prev = state;
    lat = 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_lock t%0d: got %b required %b", lat, obs, exp_vec()); end
      if (state == 3'd0) saw_hold = 1'b1;
      if (prev == 3'd2 && state == 3'd1) saw_back = 1'b1;
      prev = state;
    end
    n_tests++;
    if (lat < 9 || lat > 11) begin n_fail++; $display("FAIL glitch_latency: got %0d cycles required 9..11", lat); end
    n_tests++;
    if (saw_back !== 1'b1 || saw_hold !== 1'b0) begin
      n_fail++; $display("FAIL glitch_path: got stable_to_wait=%b hold=%b required 1 0", saw_back, saw_hold);
    end
  endtask

  task automatic test_timeout_fault();
    int entries, n;
    logic [2:0] prev;
    logic [1:0] last_r;
    int seen[$];
    restart();
    entries = 1; n = 0; prev = 3'd0; last_r = 2'd0;
    while (!fault && n < 300) begin
      tick();
      n++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout t%0d: got %b required %b", n, obs, exp_vec()); end
      if (state == 3'd0 && prev != 3'd0) entries++;
      if (retry_count != last_r) begin seen.push_back(int'(retry_count)); last_r = retry_count; end
      prev = state;
    end
    n_tests++;
    if ({fault, state, mmcm_reset} !== {1'b1, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL fault_entry: got fault=%b state=%0d mmcm=%b required 1 4 1", fault, state, mmcm_reset);
    end
    n_tests++;
    if (entries != 3) begin n_fail++; $display("FAIL hold_pulses: got %0d required 3", entries); end
    n_tests++;
    if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin
      n_fail++; $display("FAIL retry_sequence: got %p required 1 2 3", seen);
    end
    for (int i = 0; i < 6; i++) begin
      force_relock = (i == 1);
      locked_in = $urandom_range(0, 1);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL fault_sticky t%0d: got %b required %b", i, obs, exp_vec()); end
    end
    force_relock = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    n_tests++;
    if (state !== 3'd0 || retry_count !== 2'd0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL clear_fault: got %b required %b", obs, exp_vec());
    end
  endtask

  task automatic test_lock_loss();
    int n, hi;
    restart();
    locked_in = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL loss_lock t%0d: got %b required %b", n, obs, exp_vec()); end
    end
    repeat (3) tick();
    locked_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (ready !== (i < 3) || pixel_reset_n !== (i < 3)) begin
        n_fail++; $display("FAIL loss_drop c%0d: got ready=%b prst=%b required %b", i, ready, pixel_reset_n, i < 3);
      end
    end
    hi = int'(mmcm_reset);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL loss_hold t%0d: got %b required %b", i, obs, exp_vec()); end
      hi += int'(mmcm_reset);
    end
    n_tests++;
    if (hi != HOLD_C || retry_count !== 2'd0) begin
      n_fail++; $display("FAIL loss_pulse: got %0d cycles retry=%0d required %0d retry=0", hi, retry_count, HOLD_C);
    end
  endtask

  task automatic test_force_relock();
    int n;
    restart();
    locked_in = 1'b1;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    n_tests++;
    if (state !== 3'd0 || ready !== 1'b0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL relock_run: got %b required %b", obs, exp_vec());
    end
    n = 0;
    while (!(m_state == 2 && m_streak == ST_C) && n < 40) begin
      tick();
      n++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL relock_seq t%0d: got %b required %b", n, obs, exp_vec()); end
    end
    n_tests++;
    if (n >= 40) begin n_fail++; $display("FAIL relock_reach_stable: got timeout required STABLE edge"); end
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    n_tests++;
    if (state !== 3'd0 || ready !== 1'b0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL relock_vs_run: got %b required state=0 ready=0 (%b)", obs, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ready !== 1'b0 || obs !== exp_vec()) begin n_fail++; $display("FAIL relock_hold t%0d: got %b required %b", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    restart();
    locked_in = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 40) begin tick(); n++; end
    repeat (2) tick();
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL async_reset: got %b required %b", obs, RST_VEC); end
    model_reset();
    @(posedge clk_in);
    #1 reset_n = 1'b1;
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL async_restart t%0d: got %b required %b", n, obs, exp_vec()); end
    end
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL async_resequence: got ready=%b required 1", ready); end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 29) == 0) locked_in = ~locked_in;
      force_relock = ($urandom_range(0, 59) == 0);
      clear_fault = fault && ($urandom_range(0, 3) == 0);
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random t%0d: got %b required %b", i, obs, exp_vec()); end
    end
    force_relock = 1'b0;
    clear_fault = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal_lock();
    test_glitchy_lock();
    test_timeout_fault();
    test_lock_loss();
    test_force_relock();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
